// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB init sequencer: FSM states, table
// markers, default camera ID and the ms-to-cycles helper.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_SETTLE,
    ST_DONE,
    ST_ERROR,
    ST_VISSUE,
    ST_VWAIT,
    ST_VRELEASE
  } state_t;

  localparam logic [15:0] TBL_END        = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY      = 16'hFFF0;
  localparam logic [7:0]  CAM_ID_DEFAULT = 8'h42;

  function automatic longint unsigned ms_to_cycles(input longint unsigned freq,
                                                   input longint unsigned ms);
    return (freq * ms) / 64'd1000;
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Request/response bundle between the init sequencer (master) and the
// 2-wire SCCB engine (slave).
interface sccb_init_sequencer_if;
  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_id_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_id_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_id_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );
endinterface

// File: rtl/sccb_reg_rom.sv
// Registered case-ROM holding the camera register table as {sub_addr, data}
// entries; 1-cycle read latency, unused slots read as the END marker.
module sccb_reg_rom
  import sccb_pkg::*;
#(
  parameter int unsigned TBL_AW = 6
) (
  input  logic              xclk,
  input  logic [TBL_AW-1:0] addr,
  output logic [15:0]       data
);

  always_ff @(posedge xclk) begin
    case (addr)
      TBL_AW'(0): data <= 16'h1280;
      TBL_AW'(1): data <= 16'h1101;
      default:    data <= TBL_END;
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register table and drives the SCCB engine one transaction at
// a time. Define SCCB_VERIFY_EN to read back and check every write.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int unsigned XCLK_FREQ   = 10_000_000,
  parameter logic [7:0]  CAM_ID      = CAM_ID_DEFAULT,
  parameter int unsigned SETTLE_MS   = 300,
  parameter int unsigned TIMEOUT_CYC = 200_000,
  parameter int unsigned TBL_AW      = 6
) (
  input  logic                  xclk,
  input  logic                  resetn,
  input  logic                  init_go,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [TBL_AW-1:0]     err_index,
  output logic [TBL_AW-1:0]     tbl_addr,
  input  logic [15:0]           tbl_data,
  sccb_init_sequencer_if.master sccb
);

  localparam longint unsigned SETTLE_RAW = ms_to_cycles(XCLK_FREQ, SETTLE_MS);
  localparam int unsigned SETTLE_CYC = (SETTLE_RAW == 0) ? 1 : 32'(SETTLE_RAW);
  localparam int unsigned TO_CYC     = (TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC;
  localparam int unsigned CNT_MAX    = (TO_CYC > SETTLE_CYC) ? TO_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TO_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sub_q, data_q;
  logic             idle_like, go_accept, advance, tbl_last;
`ifdef SCCB_VERIFY_EN
  logic [7:0]       rd_q;
  logic             retried;
`endif

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign go_accept = idle_like && init_go;
  assign advance   = (state_nxt == ST_FETCH) && !idle_like;
  assign tbl_last  = (tbl_addr == '1);

  always_ff @(posedge xclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_t adv_st;
    adv_st    = tbl_last ? ST_DONE : ST_FETCH;
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: state_nxt = init_go ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (tbl_data == TBL_END)        state_nxt = ST_DONE;
        else if (tbl_data == TBL_DELAY) state_nxt = ST_SETTLE;
        else                            state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT_DONE;
      // done is tested first so it wins over the timeout terminal count
      ST_WAIT_DONE: begin
        if (sccb.sccb_done)           state_nxt = ST_RELEASE;
        else if (cnt == TIMEOUT_LAST) state_nxt = ST_ERROR;
      end
      ST_RELEASE: begin
`ifdef SCCB_VERIFY_EN
        if (!sccb.sccb_done) state_nxt = ST_VISSUE;
`else
        if (!sccb.sccb_done) state_nxt = adv_st;
`endif
      end
      ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = adv_st;
`ifdef SCCB_VERIFY_EN
      ST_VISSUE: state_nxt = ST_VWAIT;
      ST_VWAIT: begin
        if (sccb.sccb_done)           state_nxt = ST_VRELEASE;
        else if (cnt == TIMEOUT_LAST) state_nxt = ST_ERROR;
      end
      ST_VRELEASE: begin
        if (!sccb.sccb_done) begin
          if (rd_q == data_q) state_nxt = adv_st;
          else if (!retried)  state_nxt = ST_ISSUE;
          else                state_nxt = ST_ERROR;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge xclk or negedge resetn) begin
    if (!resetn) begin
      tbl_addr  <= '0;
      err_index <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      sub_q     <= '0;
      data_q    <= '0;
      cnt       <= '0;
`ifdef SCCB_VERIFY_EN
      rd_q      <= '0;
      retried   <= 1'b0;
`endif
    end else begin
      if (go_accept) begin
        tbl_addr  <= '0;
        err_index <= '0;
        init_done <= 1'b0;
        init_err  <= 1'b0;
      end else if (advance) begin
        tbl_addr <= tbl_addr + 1'b1;
      end
      if (state_nxt == ST_DONE) init_done <= 1'b1;
      if (state_nxt == ST_ERROR) begin
        init_err  <= 1'b1;
        err_index <= tbl_addr;
      end
      case (state)
        ST_DECODE: begin
          cnt <= '0;
          if (tbl_data != TBL_END && tbl_data != TBL_DELAY) begin
            sub_q  <= tbl_data[15:8];
            data_q <= tbl_data[7:0];
          end
`ifdef SCCB_VERIFY_EN
          retried <= 1'b0;
`endif
        end
        ST_ISSUE, ST_VISSUE:     cnt <= '0;
        ST_WAIT_DONE, ST_SETTLE: cnt <= cnt + 1'b1;
`ifdef SCCB_VERIFY_EN
        ST_VWAIT: begin
          cnt <= cnt + 1'b1;
          if (sccb.sccb_done) rd_q <= sccb.sccb_data_out;
        end
        ST_VRELEASE: if (state_nxt == ST_ISSUE) retried <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Moore outputs: an async reset forces IDLE, so sccb_start drops at once
  always_comb begin
    busy              = !idle_like;
    sccb.sccb_start   = (state == ST_ISSUE) || (state == ST_WAIT_DONE) ||
                        (state == ST_VISSUE) || (state == ST_VWAIT);
`ifdef SCCB_VERIFY_EN
    sccb.sccb_rw      = (state == ST_VISSUE) || (state == ST_VWAIT);
`else
    sccb.sccb_rw      = 1'b0;
`endif
    sccb.sccb_id_addr  = CAM_ID;
    sccb.sccb_sub_addr = sub_q;
    sccb.sccb_data_in  = data_q;
  end

endmodule
